rv_mdu: RTL and testbench

RV_MDU -- requirements
Module: rv_mdu

---
 rtl/rv_mdu.sv | 236 +++++++++++++++++++++++
 tb/tb_rv_mdu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, shared
// 2*DPWIDTH+1 bit accumulator for shift-add multiply and restoring divide.
module rv_mdu #(
    parameter int DPWIDTH   = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DPWIDTH-1:0] opa,
    input  logic [DPWIDTH-1:0] opb,
    output logic               busy,
    output logic               done,
    output logic [DPWIDTH-1:0] result
);

    localparam int W  = DPWIDTH;
    localparam int CW = $clog2(DPWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
        return en ? (-v) : v;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
        return en ? (-v) : v;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [2*W:0]    acc_r;
    logic [W-1:0]    opnd_r;
    logic [2:0]      op_r;
    logic            neg_r;
    logic            spec_r;
    logic [W-1:0]    spec_val_r;

    logic            accept_s;
    logic            early_s;
    logic            finish_s;

    logic            a_signed_s;
    logic            b_signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [W-1:0]    a_mag_s;
    logic [W-1:0]    b_mag_s;
    logic            is_div_s;
    logic            res_neg_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [W-1:0]    spec_val_s;

    logic [W:0]      mul_add_s;
    logic [W:0]      div_shift_s;
    logic [W+1:0]    div_diff_s;
    logic [2*W:0]    step_acc_s;
    logic [2*W-1:0]  prod_fix_s;
    logic [W-1:0]    div_pick_s;
    logic [W-1:0]    div_fix_s;
    logic [W-1:0]    final_s;

    // Operand signedness per funct3: MULH/DIV/REM signed*signed, MULHSU signed*unsigned
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            3'd1, 3'd4, 3'd6: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'd2: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s  = a_signed_s & opa[W-1];
    assign b_neg_s  = b_signed_s & opb[W-1];
    assign a_mag_s  = neg_w(opa, a_neg_s);
    assign b_mag_s  = neg_w(opb, b_neg_s);
    assign is_div_s = op[2];
    // Remainder follows the dividend; product and quotient follow both operands.
    assign res_neg_s = (is_div_s & op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);

    assign div_zero_s = is_div_s & (opb == {W{1'b0}});
    assign ovf_s      = is_div_s & ~op[0]
                      & (opa == {1'b1, {(W-1){1'b0}}})
                      & (opb == {W{1'b1}});
    assign special_s  = div_zero_s | ovf_s;

    // Architecturally fixed results for divide-by-zero and signed overflow
    always_comb begin
        spec_val_s = {W{1'b0}};
        if (div_zero_s) begin
            spec_val_s = op[1] ? opa : {W{1'b1}};
        end else if (ovf_s) begin
            spec_val_s = op[1] ? {W{1'b0}} : opa;
        end else begin
            spec_val_s = {W{1'b0}};
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        early_s      = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if ((EARLY_OUT != 0) && special_s) begin
                        early_s      = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(1)) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One radix-2 step: multiply adds into the high half, divide shifts and trial-subtracts
    always_comb begin
        mul_add_s   = acc_r[0] ? (acc_r[2*W:W] + {1'b0, opnd_r}) : acc_r[2*W:W];
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        if (op_r[2]) begin
            if (!div_diff_s[W+1]) begin
                step_acc_s = {div_diff_s[W:0], acc_r[W-2:0], 1'b1};
            end else begin
                step_acc_s = {div_shift_s, acc_r[W-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {1'b0, mul_add_s, acc_r[W-1:1]};
        end
    end

    assign prod_fix_s = neg_2w(step_acc_s[2*W-1:0], neg_r);
    assign div_pick_s = op_r[1] ? step_acc_s[2*W-1:W] : step_acc_s[W-1:0];
    assign div_fix_s  = neg_w(div_pick_s, neg_r);

    // Sign-corrected result selection on the last iteration
    always_comb begin
        final_s = {W{1'b0}};
        if (spec_r) begin
            final_s = spec_val_r;
        end else if (op_r[2]) begin
            final_s = div_fix_s;
        end else if (op_r[1:0] == 2'b00) begin
            final_s = prod_fix_s[W-1:0];
        end else begin
            final_s = prod_fix_s[2*W-1:W];
        end
    end

    // State register with registered busy/done decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s != IDLE);
            done    <= (state_next_s == DONE);
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*W+1){1'b0}};
            opnd_r     <= {W{1'b0}};
            op_r       <= 3'd0;
            neg_r      <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= {W{1'b0}};
        end else if (accept_s) begin
            cnt_r      <= CW'(DPWIDTH);
            acc_r      <= {{(W+1){1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
            op_r       <= op;
            neg_r      <= res_neg_s;
            spec_r     <= special_s;
            spec_val_r <= spec_val_s;
        end else if (state_r == RUN) begin
            acc_r <= step_acc_s;
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // Result changes only when entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= {W{1'b0}};
        end else if (early_s) begin
            result <= spec_val_s;
        end else if (finish_s) begin
            result <= final_s;
        end
    end

endmodule

// File: tb/tb_rv_mdu.sv
// Directed bench for rv_mdu: two instances (EARLY_OUT=1 and EARLY_OUT=0)
// share the same stimulus so latency and values can be compared per mode.
module tb_rv_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy1, done1, busy0, done0;
    logic [31:0] res1, res0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rv_mdu #(.DPWIDTH(32), .EARLY_OUT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy1), .done(done1), .result(res1)
    );

    rv_mdu #(.DPWIDTH(32), .EARLY_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy0), .done(done0), .result(res0)
    );

    // Present a start for one edge; returns at the falling edge after the start edge (cycle 1).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ex, input int lat1, input int lat0, input string nm);
        int l1, l0, bc, dc;
        l1 = 0; l0 = 0; bc = 0; dc = 0;
        issue(o, a, b);
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (busy1) bc++;
            if (done1) dc++;
            if (done1 && l1 == 0) l1 = n;
            if (done0 && l0 == 0) l0 = n;
        end
        checks++; if (l1 !== lat1) $display("FAIL %s lat_early: got %0d expected %0d", nm, l1, lat1); else passed++;
        checks++; if (l0 !== lat0) $display("FAIL %s lat_full: got %0d expected %0d", nm, l0, lat0); else passed++;
        checks++; if (res1 !== ex) $display("FAIL %s res_early: got %h expected %h", nm, res1, ex); else passed++;
        checks++; if (res0 !== ex) $display("FAIL %s res_full: got %h expected %h", nm, res0, ex); else passed++;
        checks++; if (bc !== lat1) $display("FAIL %s busy_cycles: got %0d expected %0d", nm, bc, lat1); else passed++;
        checks++; if (dc !== 1) $display("FAIL %s done_pulses: got %0d expected 1", nm, dc); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; opa = 32'd0; opb = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy1); else passed++;
        checks++; if (done1 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done1); else passed++;
        checks++; if (res1 !== 32'h0) $display("FAIL reset_result: got %h expected 0", res1); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy_full: got %b expected 0", busy0); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, "mul_7_m3");
        run_op(3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 33, 33, "mul_shift");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33, "mulhu_max");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 33, "mulh_m1");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33, "mulhsu_m1");
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 33, "mulh_min");
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, "rem_m7_2");
        run_op(3'd5, 32'd100,      32'd7,        32'd14,       33, 33, "divu_100_7");
        run_op(3'd7, 32'd100,      32'd7,        32'd2,        33, 33, "remu_100_7");
        run_op(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 33, "rem_7_m2");
    endtask

    task automatic test_special();
        run_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 33, "divu_by0");
        run_op(3'd7, 32'd5,        32'd0,        32'd5,        1, 33, "remu_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 33, "rem_ovf");
        run_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, 33, "div_by0");
        run_op(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 33, "rem_by0");
        run_op(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33, "divu_no_ovf");
        run_op(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 33, "remu_no_ovf");
    endtask

    task automatic test_ignore_start();
        int l1, l0, dc, dq;
        l1 = 0; l0 = 0; dc = 0; dq = 0;
        issue(3'd0, 32'd6, 32'd7);
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (done1) dc++;
            if (done1 && l1 == 0) l1 = n;
            if (done0 && l0 == 0) l0 = n;
            if (n == 5 || n == 33) begin
                start = 1'b1; op = 3'd5; opa = 32'd5; opb = 32'd0;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (l1 !== 33) $display("FAIL ignore_lat: got %0d expected 33", l1); else passed++;
        checks++; if (l0 !== 33) $display("FAIL ignore_lat_full: got %0d expected 33", l0); else passed++;
        checks++; if (res1 !== 32'd42) $display("FAIL ignore_res: got %h expected %h", res1, 32'd42); else passed++;
        checks++; if (res0 !== 32'd42) $display("FAIL ignore_res_full: got %h expected %h", res0, 32'd42); else passed++;
        checks++; if (dc !== 1) $display("FAIL ignore_done_pulses: got %0d expected 1", dc); else passed++;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            op  = 3'(n);
            opa = $urandom;
            opb = $urandom;
            if (done1 || done0) dq++;
        end
        checks++; if (res1 !== 32'd42) $display("FAIL hold_res: got %h expected %h", res1, 32'd42); else passed++;
        checks++; if (res0 !== 32'd42) $display("FAIL hold_res_full: got %h expected %h", res0, 32'd42); else passed++;
        checks++; if (dq !== 0) $display("FAIL hold_no_done: got %0d expected 0", dq); else passed++;
    endtask

    task automatic test_reset_mid();
        int dq;
        dq = 0;
        issue(3'd0, 32'h12345678, 32'd3);
        for (int n = 2; n <= 10; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy1); else passed++;
        checks++; if (done1 !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done1); else passed++;
        checks++; if (res1 !== 32'h0) $display("FAIL midrst_result: got %h expected 0", res1); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL midrst_busy_full: got %b expected 0", busy0); else passed++;
        checks++; if (res0 !== 32'h0) $display("FAIL midrst_result_full: got %h expected 0", res0); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) dq++;
        end
        checks++; if (dq !== 0) $display("FAIL midrst_no_activity: got %0d expected 0", dq); else passed++;
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 33, "mul_after_rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
